// File: rtl/lfsr_word_gen.sv
// Pseudo-random word generator: one XOR LFSR (Fibonacci or Galois) stepped a bit per enabled
// cycle, packing OUT_W bits into a word on a valid/ready stream with reseed and lockup recovery.
module lfsr_word_gen #(
  parameter int unsigned      WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = 16'hB400,
  parameter logic [WIDTH-1:0] SEED  = 16'hACE1,
  parameter int unsigned      MODE  = 1,
  parameter int unsigned      OUT_W = 4
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             enable_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] seed_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [OUT_W-1:0] data_o,
  output logic [WIDTH-1:0] state_o,
  output logic             lockup_o
);

  localparam int unsigned CNT_W = $clog2(OUT_W + 1);

  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  logic [WIDTH-1:0] state_q, state_d;
  logic [OUT_W-1:0] pack_q, pack_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [0:0]       fsm_q, fsm_d;
  logic             valid_q, valid_d;
  logic [OUT_W-1:0] data_q, data_d;
  logic             lockup_q, lockup_d;

  logic [WIDTH-1:0] step_state;
  logic             step_bit;
  logic [OUT_W-1:0] pack_shift;
  logic             zero_state;

  generate
    if (MODE == 0) begin : g_fib
      logic fb;
      assign fb         = ^(state_q & TAPS);
      assign step_state = {state_q[WIDTH-2:0], fb};
      assign step_bit   = fb;
    end else begin : g_gal
      assign step_bit   = state_q[0];
      assign step_state = (state_q >> 1) ^ (state_q[0] ? TAPS : '0);
    end

    // First-generated bit ends up in the MSB once OUT_W bits have been shifted in.
    if (OUT_W == 1) begin : g_pack1
      assign pack_shift = step_bit;
    end else begin : g_packn
      assign pack_shift = {pack_q[OUT_W-2:0], step_bit};
    end
  endgenerate

  assign zero_state = (state_q == '0);

  always_comb begin
    state_d  = state_q;
    pack_d   = pack_q;
    count_d  = count_q;
    fsm_d    = fsm_q;
    valid_d  = valid_q;
    data_d   = data_q;
    lockup_d = 1'b0;

    if (load_i) begin
      state_d  = (seed_i == '0) ? SEED : seed_i;
      lockup_d = (seed_i == '0);
      pack_d   = '0;
      count_d  = '0;
      valid_d  = 1'b0;
      fsm_d    = ST_FILL;
    end else begin
      // A zero state would never leave zero; recover instead of stepping this edge.
      if (zero_state) begin
        state_d  = SEED;
        lockup_d = 1'b1;
      end

      if (fsm_q == ST_HOLD) begin
        if (ready_i) begin
          valid_d = 1'b0;
          fsm_d   = ST_FILL;
        end
      end else if (enable_i && !zero_state) begin
        state_d = step_state;
        pack_d  = pack_shift;
        if (count_q == CNT_W'(OUT_W - 1)) begin
          count_d = '0;
          data_d  = pack_shift;
          valid_d = 1'b1;
          fsm_d   = ST_HOLD;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q  <= SEED;
      pack_q   <= '0;
      count_q  <= '0;
      fsm_q    <= ST_FILL;
      valid_q  <= 1'b0;
      data_q   <= '0;
      lockup_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pack_q   <= pack_d;
      count_q  <= count_d;
      fsm_q    <= fsm_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      lockup_q <= lockup_d;
    end
  end

  assign valid_o  = valid_q;
  assign data_o   = data_q;
  assign state_o  = state_q;
  assign lockup_o = lockup_q;

endmodule

// File: tb/tb_lfsr_word_gen.sv
// Directed and randomized checks of lfsr_word_gen against a word-level LFSR reference model.
module tb_lfsr_word_gen;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable, load, ready;
  logic [15:0] seed;
  logic        valid;
  logic [3:0]  data;
  logic [15:0] state;
  logic        lockup;

  logic        enable2, ready2, load2;
  logic [3:0]  seed2;
  logic        valid2;
  logic [0:0]  data2;
  logic [3:0]  state2;
  logic        lockup2;

  int checks = 0;
  int passed = 0;

  int          m_state;
  logic [3:0]  w;
  int          cyc;
  int          m2;
  int          b2;
  bit          seen [16];
  logic [15:0] t1_tab [4];
  logic [15:0] rseed;

  always #5 clk = ~clk;

  lfsr_word_gen dut (
    .clock_i (clk),
    .reset_i (reset_n),
    .enable_i(enable),
    .load_i  (load),
    .seed_i  (seed),
    .ready_i (ready),
    .valid_o (valid),
    .data_o  (data),
    .state_o (state),
    .lockup_o(lockup)
  );

  lfsr_word_gen #(
    .WIDTH(4), .TAPS(4'hC), .SEED(4'h1), .MODE(0), .OUT_W(1)
  ) dut2 (
    .clock_i (clk),
    .reset_i (reset_n),
    .enable_i(enable2),
    .load_i  (load2),
    .seed_i  (seed2),
    .ready_i (ready2),
    .valid_o (valid2),
    .data_o  (data2),
    .state_o (state2),
    .lockup_o(lockup2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Galois rule with plain arithmetic: output the low bit, halve, fold in taps if the bit was 1.
  task automatic model_word(output logic [3:0] word);
    int b;
    word = 4'h0;
    for (int i = 0; i < 4; i++) begin
      b = m_state % 2;
      word = 4'((word * 2) + b);
      m_state = (m_state / 2) ^ (b == 1 ? 'hB400 : 0);
    end
  endtask

  task automatic wait_valid(output int n, input bit rnd_en);
    n = 0;
    while (!valid && n < 200) begin
      enable = rnd_en ? 1'($urandom % 2) : 1'b1;
      tick();
      n++;
    end
    check("wait_valid", valid, 1);
  endtask

  initial begin
    t1_tab[0] = 16'hE270; t1_tab[1] = 16'h7138; t1_tab[2] = 16'h389C; t1_tab[3] = 16'h1C4E;
    reset_n = 1'b0; enable = 0; load = 0; ready = 0; seed = '0;
    enable2 = 0; ready2 = 0; load2 = 0; seed2 = '0;
    tick(); tick();
    check("rst_state", state, 16'hACE1);
    check("rst_valid", valid, 0);
    check("rst_data", data, 0);
    check("rst_lockup", lockup, 0);
    check("rst_state2", state2, 4'h1);
    reset_n = 1'b1;

    // T1: first word from the default seed
    enable = 1; ready = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t1_state", state, t1_tab[i]);
      check("t1_valid", valid, (i == 3));
    end
    check("t1_data", data, 4'h8);
    m_state = 'hACE1;
    model_word(w);
    check("t1_model_data", data, w);
    $display("word T1 data=%h state=%h", data, state);
    tick();
    check("t1_drop_valid", valid, 0);
    check("t1_no_step", state, m_state);
    ready = 0;

    // T3: backpressure freezes the word and the LFSR
    wait_valid(cyc, 0);
    check("t3_latency", cyc, 4);
    model_word(w);
    check("t3_data", data, w);
    check("t3_state", state, m_state);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t3_hold_data", data, w);
      check("t3_hold_state", state, m_state);
      check("t3_hold_valid", valid, 1);
    end
    ready = 1;
    tick();
    check("t3_drop_valid", valid, 0);
    ready = 0;
    wait_valid(cyc, 0);
    check("t3_next_latency", cyc, 4);
    model_word(w);
    check("t3_next_data", data, w);
    $display("word T3 data=%h state=%h", data, state);
    ready = 1; tick(); ready = 0;

    // Randomized enables and stall lengths
    for (int k = 0; k < 20; k++) begin
      wait_valid(cyc, 1);
      model_word(w);
      check("rnd_data", data, w);
      check("rnd_state", state, m_state);
      for (int j = 0; j < int'($urandom_range(0, 3)); j++) begin
        enable = 1'($urandom % 2);
        tick();
        check("rnd_hold", data, w);
      end
      ready = 1;
      tick();
      check("rnd_drop", valid, 0);
      check("rnd_no_step", state, m_state);
      ready = 0;
      $display("word rnd%0d data=%h state=%h cycles=%0d", k, data, state, cyc);
    end

    // T2: 4-bit Fibonacci maximal-length sequence, one bit per word
    enable2 = 1; ready2 = 1; m2 = 1;
    for (int i = 0; i < 15; i++) begin
      cyc = 0;
      while (!valid2 && cyc < 6) begin tick(); cyc++; end
      check("t2_valid", valid2, 1);
      b2 = $countones(4'(m2) & 4'hC) % 2;
      m2 = ((m2 * 2) % 16) + b2;
      check("t2_state", state2, m2);
      check("t2_bit", data2, b2);
      check("t2_nonzero", (state2 != 4'h0), 1);
      check("t2_distinct", seen[state2], 0);
      seen[state2] = 1'b1;
      $display("word T2 step%0d state=%h bit=%0d", i, state2, data2);
      tick();
    end
    check("t2_wrap", state2, 4'h1);
    enable2 = 0;

    // T5: reseed discards a pending word even with ready high
    enable = 1;
    wait_valid(cyc, 0);
    model_word(w);
    rseed = 16'($urandom_range(1, 65535));
    load = 1; ready = 1; seed = rseed;
    tick();
    load = 0; ready = 0;
    check("t5_valid", valid, 0);
    check("t5_state", state, rseed);
    check("t5_lockup", lockup, 0);
    m_state = int'(rseed);
    model_word(w);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t5_valid_rise", valid, (i == 3));
    end
    check("t5_data", data, w);
    $display("word T5 seed=%h data=%h", rseed, data);
    ready = 1; tick(); ready = 0;

    // T4: zero seed recovers to SEED with a single lockup pulse
    enable = 0;
    load = 1; seed = 16'h0000;
    tick();
    load = 0;
    check("t4_zero_state", state, 16'hACE1);
    check("t4_zero_lockup", lockup, 1);
    tick();
    check("t4_lockup_pulse", lockup, 0);
    check("t4_state_hold", state, 16'hACE1);
    load = 1; seed = 16'h1234;
    tick();
    load = 0;
    check("t4_seed_state", state, 16'h1234);
    check("t4_seed_lockup", lockup, 0);
    tick();
    check("t4_seed_lockup2", lockup, 0);
    $display("word T4 reseed state=%h", state);

    // T6: async reset mid-word, then half-rate enable
    enable = 1;
    tick(); tick();
    reset_n = 1'b0;
    #1;
    check("t6_async_state", state, 16'hACE1);
    check("t6_async_valid", valid, 0);
    tick();
    reset_n = 1'b1;
    cyc = 0;
    while (!valid && cyc < 40) begin
      enable = 1'(cyc % 2);
      tick();
      cyc++;
    end
    check("t6_latency", cyc, 8);
    check("t6_data", data, 4'h8);
    $display("word T6 data=%h cycles=%0d", data, cyc);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
